// File: rtl/video_tpg.sv
// Raster test-pattern source: YCbCr 4:4:4 with de/hs/vs/sof timing; patterns solid, h-ramp, v-ramp, color bars.
// Latency 1 clk from counter state to outputs; no backpressure. VIDEO_TPG_FRAME_CNT_EN adds frame_cnt_o and scrolling h-ramp.
module video_tpg #(
   parameter int PIXEL_WIDTH = 8,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en_i,
   input  logic [1:0]             mode_i,
   input  logic [PIXEL_WIDTH-1:0] solid_y_i,
   input  logic [PIXEL_WIDTH-1:0] solid_cb_i,
   input  logic [PIXEL_WIDTH-1:0] solid_cr_i,
   output logic [PIXEL_WIDTH-1:0] y_o,
   output logic [PIXEL_WIDTH-1:0] cb_o,
   output logic [PIXEL_WIDTH-1:0] cr_o,
   output logic                   de_o,
   output logic                   hs_o,
   output logic                   vs_o,
   output logic                   sof_o,
   output logic                   busy_o
`ifdef VIDEO_TPG_FRAME_CNT_EN
   ,
   output logic [15:0]            frame_cnt_o
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BW      = $clog2(BAR_W + 1);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
   localparam logic [PIXEL_WIDTH-1:0] MID = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [HW-1:0]   h_cnt;
   logic [VW-1:0]   v_cnt;
   logic [BW-1:0]   bar_pix;
   logic [2:0]      bar_idx;
   logic [1:0]      mode_q;
   logic            frame_end, relatch;
   logic            de_d, hs_d, vs_d, sof_d;
   logic [PIXEL_WIDTH-1:0] pix_y, pix_cb, pix_cr;
   logic [23:0]     bar_ycc;

   assign frame_end = (state == RUN) && (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign relatch   = en_i && ((state == IDLE) || frame_end);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en_i) state_nxt = RUN;
         RUN:     if (frame_end && !en_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bar counters shadow h_cnt so the bar index needs no divider.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         bar_pix <= '0;
         bar_idx <= '0;
         mode_q  <= '0;
      end else begin
         if (relatch) mode_q <= mode_i;
         if (state != RUN || h_cnt == H_LAST) begin
            h_cnt   <= '0;
            bar_pix <= '0;
            bar_idx <= '0;
         end else begin
            h_cnt <= h_cnt + 1'b1;
            if (bar_pix == BAR_LAST) begin
               bar_pix <= '0;
               bar_idx <= bar_idx + 1'b1;
            end else begin
               bar_pix <= bar_pix + 1'b1;
            end
         end
         if (state != RUN)         v_cnt <= '0;
         else if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
   end

`ifdef VIDEO_TPG_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)         frame_cnt_o <= '0;
      else if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
   end
`endif

   always_comb begin
      case (bar_idx)
         3'd0:    bar_ycc = {8'd235, 8'd128, 8'd128};
         3'd1:    bar_ycc = {8'd210, 8'd16,  8'd146};
         3'd2:    bar_ycc = {8'd170, 8'd166, 8'd16 };
         3'd3:    bar_ycc = {8'd145, 8'd54,  8'd34 };
         3'd4:    bar_ycc = {8'd106, 8'd202, 8'd222};
         3'd5:    bar_ycc = {8'd81,  8'd90,  8'd240};
         3'd6:    bar_ycc = {8'd41,  8'd240, 8'd110};
         default: bar_ycc = {8'd16,  8'd128, 8'd128};
      endcase
   end

   always_comb begin
      de_d   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_d   = (h_cnt >= HS_BEG) && (h_cnt <= HS_LST);
      vs_d   = (v_cnt >= VS_BEG) && (v_cnt <= VS_LST);
      sof_d  = de_d && (h_cnt == '0) && (v_cnt == '0);
      pix_y  = '0;
      pix_cb = '0;
      pix_cr = '0;
      if (de_d) begin
         case (mode_q)
            2'd0: begin
               pix_y  = solid_y_i;
               pix_cb = solid_cb_i;
               pix_cr = solid_cr_i;
            end
            2'd1: begin
`ifdef VIDEO_TPG_FRAME_CNT_EN
               pix_y  = PIXEL_WIDTH'(32'(h_cnt) + 32'(frame_cnt_o));
`else
               pix_y  = PIXEL_WIDTH'(h_cnt);
`endif
               pix_cb = MID;
               pix_cr = MID;
            end
            2'd2: begin
               pix_y  = PIXEL_WIDTH'(v_cnt);
               pix_cb = MID;
               pix_cr = MID;
            end
            default: begin
               pix_y  = PIXEL_WIDTH'(bar_ycc[23:16]) << (PIXEL_WIDTH - 8);
               pix_cb = PIXEL_WIDTH'(bar_ycc[15:8])  << (PIXEL_WIDTH - 8);
               pix_cr = PIXEL_WIDTH'(bar_ycc[7:0])   << (PIXEL_WIDTH - 8);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || state != RUN) begin
         y_o    <= '0;
         cb_o   <= '0;
         cr_o   <= '0;
         de_o   <= 1'b0;
         hs_o   <= 1'b0;
         vs_o   <= 1'b0;
         sof_o  <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         y_o    <= pix_y;
         cb_o   <= pix_cb;
         cr_o   <= pix_cr;
         de_o   <= de_d;
         hs_o   <= hs_d;
         vs_o   <= vs_d;
         sof_o  <= sof_d;
         busy_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_video_tpg.sv
// Scoreboard bench for video_tpg: frame-position reference model feeds a queue, a monitor compares each clock.
module tb_video_tpg;
   localparam int PW = 8;
   localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
   localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FR = HT * VT;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en_i = 1'b0;
   logic [1:0]    mode_i = 2'd0;
   logic [PW-1:0] sy = '0, scb = '0, scr = '0;
   logic [PW-1:0] y_o, cb_o, cr_o;
   logic          de_o, hs_o, vs_o, sof_o, busy_o;
`ifdef VIDEO_TPG_FRAME_CNT_EN
   logic [15:0]   frame_cnt_o;
`endif

   always #5 clk = ~clk;

   video_tpg #(
      .PIXEL_WIDTH(PW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i),
      .solid_y_i(sy), .solid_cb_i(scb), .solid_cr_i(scr),
      .y_o(y_o), .cb_o(cb_o), .cr_o(cr_o),
      .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .sof_o(sof_o), .busy_o(busy_o)
`ifdef VIDEO_TPG_FRAME_CNT_EN
      , .frame_cnt_o(frame_cnt_o)
`endif
   );

   typedef struct packed {
      logic [PW-1:0] y, cb, cr;
      logic          de, hs, vs, sof, busy;
      logic [15:0]   fc;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;
   int   de_n = 0, sof_n = 0, hs_n = 0, vs_n = 0;

   // Reference model: run flag, position within the frame, latched pattern, frame count.
   bit   m_run = 1'b0;
   int   m_pos = 0, m_mode = 0, m_fc = 0;
   int   bar_y[8]  = '{235, 210, 170, 145, 106, 81, 41, 16};
   int   bar_cb[8] = '{128, 16, 166, 54, 202, 90, 240, 128};
   int   bar_cr[8] = '{128, 146, 16, 34, 222, 240, 110, 128};

   function automatic exp_t model_out();
      exp_t e;
      int   h, v, scroll;
      e = '0;
      if (rst_n && m_run) begin
         h = m_pos % HT;
         v = m_pos / HT;
`ifdef VIDEO_TPG_FRAME_CNT_EN
         scroll = m_fc;
`else
         scroll = 0;
`endif
         e.busy = 1'b1;
         e.de   = (h < HA) && (v < VA);
         e.hs   = (h >= HA + HFP) && (h < HA + HFP + HSW);
         e.vs   = (v >= VA + VFP) && (v < VA + VFP + VSW);
         e.sof  = e.de && (m_pos == 0);
         if (e.de) begin
            case (m_mode)
               0: begin e.y = sy; e.cb = scb; e.cr = scr; end
               1: begin e.y = PW'((h + scroll) % 256); e.cb = PW'(128); e.cr = PW'(128); end
               2: begin e.y = PW'(v); e.cb = PW'(128); e.cr = PW'(128); end
               default: begin
                  e.y  = PW'(bar_y[h / (HA / 8)]);
                  e.cb = PW'(bar_cb[h / (HA / 8)]);
                  e.cr = PW'(bar_cr[h / (HA / 8)]);
               end
            endcase
         end
      end
      return e;
   endfunction

   task automatic step();
      exp_t e;
      e = model_out();
      if (!rst_n) begin
         m_run = 1'b0; m_pos = 0; m_mode = 0; m_fc = 0;
      end else if (!m_run) begin
         if (en_i) begin m_run = 1'b1; m_pos = 0; m_mode = int'(mode_i); end
      end else if (m_pos == FR - 1) begin
         m_fc  = (m_fc + 1) % 65536;
         m_pos = 0;
         if (en_i) m_mode = int'(mode_i);
         else      m_run = 1'b0;
      end else begin
         m_pos++;
      end
      e.fc = 16'(m_fc);
      q.push_back(e);
   endtask

   // Inputs are set at a falling edge, the expectation for the next rising edge is queued, then one cycle passes.
   task automatic run(input int n);
      repeat (n) begin
         step();
         @(negedge clk);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic clear_counts();
      de_n = 0; sof_n = 0; hs_n = 0; vs_n = 0;
   endtask

   initial begin : monitor
      exp_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{y: y_o, cb: cb_o, cr: cr_o, de: de_o, hs: hs_o, vs: vs_o,
                  sof: sof_o, busy: busy_o, fc: 16'd0};
            checks++;
            if (a[$bits(exp_t)-1:16] !== e[$bits(exp_t)-1:16]) begin
               errors++;
               $display("FAIL pix t=%0t got y=%0d cb=%0d cr=%0d de=%b hs=%b vs=%b sof=%b busy=%b expected y=%0d cb=%0d cr=%0d de=%b hs=%b vs=%b sof=%b busy=%b",
                        $time, a.y, a.cb, a.cr, a.de, a.hs, a.vs, a.sof, a.busy,
                        e.y, e.cb, e.cr, e.de, e.hs, e.vs, e.sof, e.busy);
            end
`ifdef VIDEO_TPG_FRAME_CNT_EN
            checks++;
            if (frame_cnt_o !== e.fc) begin
               errors++;
               $display("FAIL frame_cnt t=%0t got %0d expected %0d", $time, frame_cnt_o, e.fc);
            end
`endif
            if (de_o === 1'b1)  de_n++;
            if (sof_o === 1'b1) sof_n++;
            if (hs_o === 1'b1)  hs_n++;
            if (vs_o === 1'b1)  vs_n++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      rst_n = 1'b0; en_i = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(3);

      // Two full h-ramp frames from the enable edge.
      clear_counts();
      en_i = 1'b1; mode_i = 2'd1;
      run(2 * FR);
      check_int("ramp_de_count", de_n, 2 * 32);
      check_int("ramp_sof_count", sof_n, 2);
      check_int("ramp_hs_count", hs_n, 2 * 2 * VT);
      check_int("ramp_vs_count", vs_n, 2 * HT);

      // Bars latched at the frame boundary; mid-frame switch to v-ramp waits for the next frame.
      clear_counts();
      mode_i = 2'd3;
      run(40);
      mode_i = 2'd2;
      run(FR - 40);
      check_int("bars_de_count", de_n, 32);
      run(FR);

      // Solid colour with live-sampled inputs.
      mode_i = 2'd0;
      for (int i = 0; i < FR; i++) begin
         sy  = PW'($urandom_range(0, 255));
         scb = PW'($urandom_range(0, 255));
         scr = PW'($urandom_range(0, 255));
         run(1);
      end

      // Graceful stop 40 cycles into a frame.
      clear_counts();
      mode_i = 2'd1;
      run(40);
      en_i = 1'b0;
      run(120);
      check_int("stop_de_count", de_n, 32);
      check_int("stop_sof_count", sof_n, 1);
      check_int("stop_busy", int'(busy_o), 0);

      // Reset inside an active line, then restart.
      clear_counts();
      en_i = 1'b1; mode_i = 2'd1;
      run(20);
      rst_n = 1'b0;
      run(2);
      check_int("reset_de", int'(de_o), 0);
      check_int("reset_busy", int'(busy_o), 0);
      rst_n = 1'b1;
      run(30);
      check_int("reset_sof_count", sof_n, 2);

      // Randomized run with occasional enable drops and resets.
      for (int i = 0; i < 600; i++) begin
         en_i   = ($urandom_range(0, 9) != 0);
         mode_i = 2'($urandom_range(0, 3));
         rst_n  = ($urandom_range(0, 199) != 0);
         sy     = PW'($urandom);
         scb    = PW'($urandom);
         scr    = PW'($urandom);
         run(1);
      end

      rst_n = 1'b1; en_i = 1'b0;
      run(2 * FR);
      check_int("final_busy", int'(busy_o), 0);
      check_int("final_de", int'(de_o), 0);
      check_int("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
